// File: rtl/microtan_pkg.sv
// Shared types and constants for the Microtan RAM arbiter: owner tags and RAM geometry.
package microtan_pkg;

    localparam int unsigned RAM_AW        = 13;
    localparam int unsigned RAM_DW        = 9;
    localparam int unsigned VID_AW        = 9;
    localparam logic [3:0]  VID_BASE_PAGE = 4'b0001;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the CPU has absolute priority, the video fetcher takes every free cycle.
// Build option RAM_GFX_BIT_EN stores/returns the graphics attribute in RAM bit 8.
module ram_arbiter
    import microtan_pkg::*;
#(
    parameter int unsigned AW       = RAM_AW,
    parameter logic [3:0]  VID_BASE = VID_BASE_PAGE,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [AW-1:0]        cpu_addr_i,
    input  logic [7:0]           cpu_wdata_i,
    input  logic                 cpu_gfx_i,
    output logic [7:0]           cpu_rdata_o,
    output logic                 cpu_rvalid_o,
    output logic                 cpu_ovr_o,

    input  logic                 vid_req_i,
    input  logic [VID_AW-1:0]    vid_addr_i,
    output logic                 vid_ack_o,
    output logic [RAM_DW-1:0]    vid_rdata_o,
    output logic                 vid_rvalid_o,
    output logic [WAIT_W-1:0]    vid_wait_o,

    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic [AW-1:0]        ram_addr_o,
    output logic [RAM_DW-1:0]    ram_wdata_o,
    input  logic [RAM_DW-1:0]    ram_rdata_i
);

    localparam logic [WAIT_W-1:0] WaitMax = '1;

    // Holds the RAM idle for the first cycle after reset release.
    logic run_q;

    logic          cpu_pend_q;
    logic          cpu_we_q;
    logic [AW-1:0] cpu_addr_q;
    logic [7:0]    cpu_wdata_q;
    logic          wdata_gfx;
    logic          rdata_gfx;

    owner_e tag_d, tag0_q, tag1_q;
    logic   cpu_issue;

    logic [7:0]        cpu_rdata_q;
    logic [RAM_DW-1:0] vid_rdata_q;
    logic              cpu_ovr_q;

    logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q, wait_max_q;

`ifdef RAM_GFX_BIT_EN
    logic cpu_gfx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cpu_gfx_q <= 1'b0;
        end else if (cpu_req_i) begin
            cpu_gfx_q <= cpu_gfx_i;
        end
    end

    assign wdata_gfx = cpu_addr_q[9] & cpu_gfx_q;
    assign rdata_gfx = ram_rdata_i[8];
`else
    logic unused_gfx;
    assign unused_gfx = cpu_gfx_i ^ ram_rdata_i[8];
    assign wdata_gfx  = 1'b0;
    assign rdata_gfx  = 1'b0;
`endif

    // Issue mux: the pending CPU command always wins the slot.
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        vid_ack_o   = 1'b0;
        cpu_issue   = 1'b0;
        tag_d       = OWN_NONE;
        if (run_q && cpu_pend_q) begin
            cpu_issue   = 1'b1;
            ram_en_o    = 1'b1;
            ram_we_o    = cpu_we_q;
            ram_addr_o  = cpu_addr_q;
            ram_wdata_o = {wdata_gfx, cpu_wdata_q};
            tag_d       = cpu_we_q ? OWN_NONE : OWN_CPU;
        end else if (run_q && vid_req_i) begin
            ram_en_o   = 1'b1;
            ram_addr_o = AW'({VID_BASE, vid_addr_i});
            vid_ack_o  = 1'b1;
            tag_d      = OWN_VID;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (vid_req_i && !vid_ack_o) begin
            wait_cnt_d = (wait_cnt_q == WaitMax) ? WaitMax : wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q       <= 1'b0;
            cpu_pend_q  <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            cpu_ovr_q   <= 1'b0;
            tag0_q      <= OWN_NONE;
            tag1_q      <= OWN_NONE;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            wait_cnt_q  <= '0;
            wait_max_q  <= '0;
        end else begin
            run_q <= 1'b1;

            if (cpu_req_i) begin
                cpu_pend_q  <= 1'b1;
                cpu_we_q    <= cpu_we_i;
                cpu_addr_q  <= cpu_addr_i;
                cpu_wdata_q <= cpu_wdata_i;
            end else if (cpu_issue) begin
                cpu_pend_q <= 1'b0;
            end

            // A new request while the previous one is queued or its read is in flight.
            if (cpu_req_i && (cpu_pend_q || tag0_q == OWN_CPU || tag1_q == OWN_CPU)) begin
                cpu_ovr_q <= 1'b1;
            end

            tag0_q <= tag_d;
            tag1_q <= tag0_q;
            if (tag0_q == OWN_CPU) begin
                cpu_rdata_q <= ram_rdata_i[7:0];
            end
            if (tag0_q == OWN_VID) begin
                vid_rdata_q <= {rdata_gfx, ram_rdata_i[7:0]};
            end

            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d > wait_max_q) begin
                wait_max_q <= wait_cnt_d;
            end
        end
    end

    assign cpu_rdata_o  = cpu_rdata_q;
    assign cpu_rvalid_o = (tag1_q == OWN_CPU);
    assign cpu_ovr_o    = cpu_ovr_q;
    assign vid_rdata_o  = vid_rdata_q;
    assign vid_rvalid_o = (tag1_q == OWN_VID);
    assign vid_wait_o   = wait_max_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table-driven CPU vectors, scoreboarded read returns, corner sequences.
module tb_ram_arbiter;
    import microtan_pkg::*;

`ifdef RAM_GFX_BIT_EN
    localparam bit GfxEn = 1'b1;
`else
    localparam bit GfxEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0, cpu_gfx = 1'b0;
    logic [12:0]       cpu_addr = '0;
    logic [7:0]        cpu_wdata = '0;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid, cpu_ovr;
    logic              vid_req = 1'b0;
    logic [8:0]        vid_addr = '0;
    logic              vid_ack, vid_rvalid;
    logic [8:0]        vid_rdata;
    logic [3:0]        vid_wait;
    logic              ram_en, ram_we;
    logic [12:0]       ram_addr;
    logic [8:0]        ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_gfx_i    (cpu_gfx),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_rvalid_o (cpu_rvalid),
        .cpu_ovr_o    (cpu_ovr),
        .vid_req_i    (vid_req),
        .vid_addr_i   (vid_addr),
        .vid_ack_o    (vid_ack),
        .vid_rdata_o  (vid_rdata),
        .vid_rvalid_o (vid_rvalid),
        .vid_wait_o   (vid_wait),
        .ram_en_o     (ram_en),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
    );

    function automatic logic [8:0] pat(input int a);
        return 9'((a * 7 + 3) ^ (a >> 5));
    endfunction

    function automatic logic [8:0] vexp(input int a);
        logic [8:0] p;
        p = pat(a);
        return GfxEn ? p : {1'b0, p[7:0]};
    endfunction

    // Behavioural 8K x 9 RAM, read data one clock after ram_en.
    logic [8:0] mem [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = pat(i);
        mem[13'h0123] = 9'h05A;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int stray = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [8:0]  data;
        int unsigned due;
    } exp_t;

    exp_t cpu_q[$];
    exp_t vid_q[$];

    task automatic push_cpu(input logic [8:0] d, input int unsigned due);
        exp_t e;
        e.data = d;
        e.due  = due;
        cpu_q.push_back(e);
    endtask

    task automatic push_vid(input logic [8:0] d, input int unsigned due);
        exp_t e;
        e.data = d;
        e.due  = due;
        vid_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                stray++;
                $display("FAIL cpu_rvalid_unexpected: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = cpu_q.pop_front();
                check("cpu_rdata", 64'(cpu_rdata), 64'(e.data[7:0]));
                check("cpu_rvalid_cycle", 64'(cyc), 64'(e.due));
            end
        end
        if (vid_rvalid) begin
            if (vid_q.size() == 0) begin
                stray++;
                $display("FAIL vid_rvalid_unexpected: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = vid_q.pop_front();
                check("vid_rdata", 64'(vid_rdata), 64'(e.data));
                check("vid_rvalid_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle CPU strobe; returns one cycle later, in the issue cycle.
    task automatic cpu_cmd(input logic we, input logic [12:0] a, input logic [7:0] d,
                           input logic g);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_gfx   = g;
        step(1);
        cpu_req   = 1'b0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cpu_rdata, cpu_rvalid, cpu_ovr, vid_ack, vid_rdata, vid_rvalid, vid_wait,
                    ram_en, ram_we, ram_addr, ram_wdata});
    endfunction

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        gfx;
        logic [8:0]  exp;   // ram_wdata for writes, returned data for reads
    } vec_t;

    vec_t vecs[8];

    initial begin
        int unsigned n;

        vecs[0] = '{1'b0, 13'h0123, 8'h00, 1'b0, 9'h05A};
        vecs[1] = '{1'b1, 13'h0205, 8'h81, 1'b1, GfxEn ? 9'h181 : 9'h081};
        vecs[2] = '{1'b0, 13'h0205, 8'h00, 1'b0, 9'h081};
        vecs[3] = '{1'b1, 13'h1FFF, 8'hC3, 1'b1, GfxEn ? 9'h1C3 : 9'h0C3};
        vecs[4] = '{1'b1, 13'h0000, 8'h7E, 1'b1, 9'h07E};
        vecs[5] = '{1'b1, 13'h0300, 8'h55, 1'b0, 9'h055};
        vecs[6] = '{1'b0, 13'h1FFF, 8'h00, 1'b0, 9'h0C3};
        vecs[7] = '{1'b0, 13'h0000, 8'h00, 1'b0, 9'h07E};

        // Reset state
        step(2);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        step(3);

        // Reset asserted while a CPU read is in flight: dropped, never returned
        cpu_cmd(1'b0, 13'h0123, 8'h00, 1'b0);
        step(1);
        rst_n   = 1'b0;
        vid_req = 1'b1;
        #1;
        check("midread_reset_outputs", all_outs(), 64'd0);
        step(2);
        vid_req = 1'b0;
        rst_n   = 1'b1;
        step(8);

        // Table of CPU accesses
        foreach (vecs[i]) begin
            n = cyc;
            cpu_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gfx);
            @(negedge clk);
            check("vec_ram_en", 64'(ram_en), 64'd1);
            check("vec_ram_we", 64'(ram_we), 64'(vecs[i].we));
            check("vec_ram_addr", 64'(ram_addr), 64'(vecs[i].addr));
            if (vecs[i].we) check("vec_ram_wdata", 64'(ram_wdata), 64'(vecs[i].exp));
            else            push_cpu(vecs[i].exp, n + 3);
            step(8);
        end
        check("no_ovr_at_legal_rate", 64'(cpu_ovr), 64'd0);

        // Video streaming with the CPU idle: an ack every cycle, data back in order
        vid_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vid_addr = 9'(16 + i);
            push_vid(vexp(13'h0200 + 16 + i), cyc + 2);
            @(negedge clk);
            check("vid_stream_ack", 64'(vid_ack), 64'd1);
            check("vid_stream_addr", 64'(ram_addr), 64'(13'h0200 + 16 + i));
            step(1);
        end
        vid_req = 1'b0;
        step(4);
        check("vid_wait_idle_cpu", 64'(vid_wait), 64'd0);

        // CPU request together with video: CPU owns the next slot, video resumes after
        n         = cyc;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 13'h0123;
        vid_req   = 1'b1;
        vid_addr  = 9'h1FE;
        @(negedge clk);
        check("contend_vid_ack_n", 64'(vid_ack), 64'd1);
        check("contend_addr_n", 64'(ram_addr), 64'h03FE);
        push_vid(vexp(13'h03FE), n + 2);
        step(1);
        cpu_req  = 1'b0;
        vid_addr = 9'h1FF;
        push_cpu(9'h05A, n + 3);
        @(negedge clk);
        check("contend_cpu_en", 64'(ram_en), 64'd1);
        check("contend_cpu_we", 64'(ram_we), 64'd0);
        check("contend_cpu_addr", 64'(ram_addr), 64'h0123);
        check("contend_vid_yield", 64'(vid_ack), 64'd0);
        step(1);
        @(negedge clk);
        check("contend_vid_ack", 64'(vid_ack), 64'd1);
        check("contend_vid_addr", 64'(ram_addr), 64'h03FF);
        push_vid(vexp(13'h03FF), n + 4);
        step(1);
        vid_req = 1'b0;
        step(5);
        check("vid_wait_one", 64'(vid_wait), 64'd1);
        check("no_ovr_before_burst", 64'(cpu_ovr), 64'd0);

        // Two reads 3 clocks apart: overrun flagged and sticky until reset
        n = cyc;
        cpu_cmd(1'b0, 13'h0123, 8'h00, 1'b0);
        push_cpu(9'h05A, n + 3);
        step(2);
        n = cyc;
        cpu_cmd(1'b0, 13'h1FFF, 8'h00, 1'b0);
        push_cpu(9'h0C3, n + 3);
        step(8);
        check("ovr_set", 64'(cpu_ovr), 64'd1);
        step(10);
        check("ovr_sticky", 64'(cpu_ovr), 64'd1);
        rst_n = 1'b0;
        #2;
        check("ovr_cleared_by_reset", 64'(cpu_ovr), 64'd0);
        check("vid_wait_cleared_by_reset", 64'(vid_wait), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(4);

        check("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);
        check("vid_queue_drained", 64'(vid_q.size()), 64'd0);
        check("stray_rvalid", 64'(stray), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
